// File: rtl/reg_share_arbiter.sv
// Round-robin arbiter granting N requesters write access to one shared W-bit register,
// with an optional cool-down gap after each grant.
module reg_share_arbiter #(
  parameter int N   = 4,
  parameter int W   = 8,
  parameter int GAP = 0
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic [N-1:0]                           req,
  input  logic [N*W-1:0]                         wdata,
  output logic [N-1:0]                           gnt,
  output logic [W-1:0]                           q,
  output logic                                   upd,
  output logic [((N > 1) ? $clog2(N) : 1)-1:0]   owner,
  output logic                                   busy
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    COOL  = 2'd2
  } state_t;

  state_t        state_r, next_state_s;
  logic [3:0]    cnt_r, cnt_nxt_s;
  logic [IW-1:0] ptr_r, win_s;
  logic          load_s;

  // First set request bit at or after p, wrapping modulo N.
  function automatic logic [IW-1:0] rr_pick(input logic [N-1:0] r, input logic [IW-1:0] p);
    logic [IW-1:0] w;
    int            idx;
    w = {IW{1'b0}};
    for (int i = N - 1; i >= 0; i--) begin
      idx = (int'(p) + i) % N;
      if (r[idx]) begin
        w = IW'(idx);
      end else begin
        w = w;
      end
    end
    return w;
  endfunction

  assign win_s = rr_pick(req, ptr_r);

  // Next-state, cool-down counter and load decision.
  always_comb begin
    next_state_s = state_r;
    cnt_nxt_s    = cnt_r;
    load_s       = 1'b0;
    case (state_r)
      IDLE: begin
        if (req != {N{1'b0}}) begin
          load_s       = 1'b1;
          next_state_s = GRANT;
        end else begin
          next_state_s = IDLE;
        end
      end
      GRANT: begin
        if (GAP > 0) begin
          next_state_s = COOL;
          cnt_nxt_s    = 4'(GAP - 1);
        end else begin
          next_state_s = IDLE;
        end
      end
      COOL: begin
        if (cnt_r == 4'd0) begin
          next_state_s = IDLE;
        end else begin
          cnt_nxt_s = cnt_r - 4'd1;
        end
      end
      default: begin
        next_state_s = IDLE;
        cnt_nxt_s    = 4'd0;
      end
    endcase
  end

  // State, pointer and registered outputs; reset wins over any pending grant or cool-down.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
      cnt_r   <= 4'd0;
      ptr_r   <= {IW{1'b0}};
      gnt     <= {N{1'b0}};
      q       <= {W{1'b0}};
      upd     <= 1'b0;
      owner   <= {IW{1'b0}};
      busy    <= 1'b0;
    end else begin
      state_r <= next_state_s;
      cnt_r   <= cnt_nxt_s;
      busy    <= (next_state_s != IDLE);
      if (load_s) begin
        q     <= wdata[win_s*W +: W];
        gnt   <= {{(N-1){1'b0}}, 1'b1} << win_s;
        upd   <= 1'b1;
        owner <= win_s;
        ptr_r <= (win_s == IW'(N - 1)) ? {IW{1'b0}} : win_s + IW'(1);
      end else begin
        gnt   <= {N{1'b0}};
        upd   <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_reg_share_arbiter.sv
// Randomized self-checking bench: two arbiters (GAP=0 and GAP=3) share stimulus and are
// compared each cycle against an edge-count based reference model.
module tb_reg_share_arbiter;

  localparam int N = 4;
  localparam int W = 8;
  localparam int GAPS [2] = '{0, 3};

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req;
  logic [N*W-1:0] wdata;

  logic [N-1:0]   gnt_w   [2];
  logic [W-1:0]   q_w     [2];
  logic           upd_w   [2];
  logic [1:0]     owner_w [2];
  logic           busy_w  [2];

  always #5 clk = ~clk;

  reg_share_arbiter #(.N(N), .W(W), .GAP(0)) dut0 (
    .clk(clk), .rst(rst), .req(req), .wdata(wdata),
    .gnt(gnt_w[0]), .q(q_w[0]), .upd(upd_w[0]), .owner(owner_w[0]), .busy(busy_w[0])
  );

  reg_share_arbiter #(.N(N), .W(W), .GAP(3)) dut3 (
    .clk(clk), .rst(rst), .req(req), .wdata(wdata),
    .gnt(gnt_w[1]), .q(q_w[1]), .upd(upd_w[1]), .owner(owner_w[1]), .busy(busy_w[1])
  );

  int n_vec = 0;
  int n_err = 0;

  // Reference model: arbitration is allowed from edge m_next onward; a grant at edge t
  // pushes that to t+2+GAP and keeps busy high after edges t..t+GAP.
  int             cyc = 0;
  int             m_next [2] = '{0, 0};
  int             m_ptr  [2] = '{0, 0};
  logic [N-1:0]   e_gnt  [2];
  logic [W-1:0]   e_q    [2];
  logic           e_upd  [2];
  logic [1:0]     e_owner[2];
  logic           e_busy [2];

  always @(posedge clk) begin
    int k;
    cyc++;
    for (int d = 0; d < 2; d++) begin
      e_gnt[d] = '0;
      e_upd[d] = 1'b0;
      if (rst) begin
        e_q[d] = '0; e_owner[d] = '0; e_busy[d] = 1'b0;
        m_ptr[d] = 0; m_next[d] = 0;
      end else begin
        if (cyc >= m_next[d] && req != '0) begin
          k = -1;
          for (int off = 0; off < N; off++)
            if (k < 0 && req[(m_ptr[d] + off) % N]) k = (m_ptr[d] + off) % N;
          e_q[d]     = wdata[k*W +: W];
          e_gnt[d]   = N'(1) << k;
          e_upd[d]   = 1'b1;
          e_owner[d] = 2'(k);
          m_ptr[d]   = (k + 1) % N;
          m_next[d]  = cyc + 2 + GAPS[d];
        end
        e_busy[d] = (cyc < m_next[d] - 1);
      end
    end
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic compare_all();
    for (int d = 0; d < 2; d++) begin
      check_val($sformatf("d%0d_gnt", d),   32'(gnt_w[d]),   32'(e_gnt[d]));
      check_val($sformatf("d%0d_q", d),     32'(q_w[d]),     32'(e_q[d]));
      check_val($sformatf("d%0d_upd", d),   32'(upd_w[d]),   32'(e_upd[d]));
      check_val($sformatf("d%0d_owner", d), 32'(owner_w[d]), 32'(e_owner[d]));
      check_val($sformatf("d%0d_busy", d),  32'(busy_w[d]),  32'(e_busy[d]));
      check_val($sformatf("d%0d_onehot", d), 32'($countones(gnt_w[d]) <= 1), 32'd1);
    end
  endtask

  // One clock edge, then check on the falling edge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
    compare_all();
  endtask

  initial begin
    rst   = 1'b1;
    req   = 4'b1111;
    for (int i = 0; i < N; i++) wdata[i*W +: W] = 8'h10 + 8'(i);
    repeat (3) begin
      step();
      check_val("rst_q",    32'(q_w[0]),    32'd0);
      check_val("rst_busy", 32'(busy_w[1]), 32'd0);
    end

    // First grant after reset goes to requester 0.
    rst = 1'b0;
    step();
    check_val("first_gnt", 32'(gnt_w[0]), 32'h1);
    check_val("first_gnt_gap", 32'(gnt_w[1]), 32'h1);
    req = '0;
    repeat (6) step();

    // Single request from requester 1.
    req = 4'b0010;
    wdata[1*W +: W] = 8'hA5;
    step();
    check_val("single_gnt",   32'(gnt_w[0]),   32'h2);
    check_val("single_q",     32'(q_w[0]),     32'hA5);
    check_val("single_owner", 32'(owner_w[0]), 32'd1);
    check_val("single_busy",  32'(busy_w[0]),  32'd1);
    req = '0;
    step();
    check_val("single_drop", 32'(gnt_w[0]), 32'h0);
    check_val("single_hold", 32'(q_w[0]),   32'hA5);
    repeat (5) step();

    // All requesters held: rotation 2,3,0,1 for the GAP=0 arbiter (ptr is 2).
    for (int i = 0; i < N; i++) wdata[i*W +: W] = 8'h10 + 8'(i);
    req = 4'b1111;
    repeat (12) step();

    // Skip and wrap with two sparse requesters.
    req = 4'b0101;
    repeat (12) step();
    req = '0;
    repeat (6) step();

    // Reset in the GAP=3 arbiter's GRANT cycle discards the cool-down.
    req = 4'b0001;
    wdata[0 +: W] = 8'h5C;
    step();
    check_val("mid_pre_busy", 32'(busy_w[1]), 32'd1);
    rst = 1'b1;
    step();
    check_val("mid_rst_busy", 32'(busy_w[1]), 32'd0);
    check_val("mid_rst_q",    32'(q_w[1]),    32'd0);
    rst = 1'b0;
    req = 4'b1001;
    step();
    check_val("mid_first", 32'(gnt_w[1]), 32'h1);
    repeat (5) step();
    check_val("mid_second", 32'(gnt_w[1]), 32'h8);
    req = '0;
    repeat (6) step();

    // Randomized traffic, including occasional resets and short req pulses.
    for (int n = 0; n < 600; n++) begin
      rst = ($urandom_range(0, 59) == 0);
      if ($urandom_range(0, 9) < 6) req = N'($urandom_range(0, 15));
      wdata = ($urandom_range(0, 3) == 0) ? wdata : (N*W)'($urandom);
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
